// File: rtl/romulus_config_pkg.sv
// Shared constants, state encoding and round-constant LFSR step for the Romulus TBC control path.
package romulus_config_pkg;

  localparam int          NUM_RNDS = 40;
  localparam int          RC_W     = 6;
  localparam logic [5:0]  RC_SEED  = 6'h00;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_CORR  = 2'd2,
    SEQ_CSTEP = 2'd3
  } seq_state_t;

  // SKINNY 6-bit round-constant LFSR, one step
  function automatic logic [RC_W-1:0] rc_step(input logic [RC_W-1:0] rc);
    return {rc[4:0], ~(rc[5] ^ rc[4])};
  endfunction

endpackage

// File: rtl/romulus_rc_lfsr.sv
// Combinational multi-step round-constant LFSR; emits the packed constants of one clock.
module romulus_rc_lfsr
  import romulus_config_pkg::*;
#(
  parameter int RNDS_PER_CLK = 1,
  localparam int CONSTW      = RC_W * RNDS_PER_CLK
) (
  input  logic [RC_W-1:0]   rc_in,
  output logic [CONSTW-1:0] rc_vec
);

  logic [RC_W-1:0] r;

  // round k of the clock lands at [6k+5:6k]; the top slice seeds the next clock
  always_comb begin
    rc_vec = '0;
    r      = rc_in;
    for (int k = 0; k < RNDS_PER_CLK; k++) begin
      r                    = rc_step(r);
      rc_vec[RC_W*k +: RC_W] = r;
    end
  end

endmodule

// File: rtl/romulus_tbc_sequencer.sv
// Sequences one SKINNY-128-384 TBC call (rounds + tweakey correction) or a single counter step.
module romulus_tbc_sequencer
  import romulus_config_pkg::*;
#(
  parameter int RNDS_PER_CLK = 1,
  parameter int N_RNDS       = NUM_RNDS,
  localparam int CONSTW      = RC_W * RNDS_PER_CLK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cnt_step,
  output logic              busy,
  output logic              done,
  output logic [CONSTW-1:0] constant,
  output logic [5:0]        rnd,
  output logic              sen,
  output logic              senc,
  output logic              xen,
  output logic              xenc,
  output logic              yen,
  output logic              yenc,
  output logic              zen,
  output logic              zenc,
  output logic              correct_cnt
);

  localparam logic [5:0] RND_MAX  = 6'(N_RNDS);
  localparam logic [5:0] RND_STEP = 6'(RNDS_PER_CLK);
  localparam logic [5:0] RND_LAST = 6'(N_RNDS - RNDS_PER_CLK);

  seq_state_t        state_q, state_d;
  logic [CONSTW-1:0] rc_q;
  logic [CONSTW-1:0] rc_next;
  logic [RC_W-1:0]   lfsr_in;
  logic [5:0]        rnd_q;
  logic              done_q;

  // from IDLE the seed produces the first clock's constants
  assign lfsr_in = (state_q == SEQ_IDLE) ? RC_SEED : rc_q[CONSTW-1 -: RC_W];

  romulus_rc_lfsr #(.RNDS_PER_CLK(RNDS_PER_CLK)) u_rc_lfsr (
    .rc_in  (lfsr_in),
    .rc_vec (rc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      rc_q    <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == SEQ_CORR) || (state_q == SEQ_CSTEP);
      if (state_q == SEQ_IDLE && start) begin
        rc_q  <= rc_next;
        rnd_q <= '0;
      end else if (state_q == SEQ_RUN) begin
        rc_q  <= rc_next;
        rnd_q <= (rnd_q > RND_MAX - RND_STEP) ? RND_MAX : rnd_q + RND_STEP;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    constant    = '0;
    sen         = 1'b0;
    senc        = 1'b0;
    xen         = 1'b0;
    xenc        = 1'b0;
    yen         = 1'b0;
    yenc        = 1'b0;
    zen         = 1'b0;
    zenc        = 1'b0;
    correct_cnt = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (start)         state_d = SEQ_RUN;
        else if (cnt_step) state_d = SEQ_CSTEP;
      end
      SEQ_RUN: begin
        {sen, senc, xen, xenc, yen, yenc, zen, zenc} = 8'hFF;
        constant = rc_q;
        if (rnd_q == RND_LAST) state_d = SEQ_CORR;
      end
      SEQ_CORR: begin
        // tweakey correction; state register holds the ciphertext
        xen     = 1'b1;
        yen     = 1'b1;
        zen     = 1'b1;
        state_d = SEQ_IDLE;
      end
      SEQ_CSTEP: begin
        zen         = 1'b1;
        correct_cnt = 1'b1;
        state_d     = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  assign busy = (state_q != SEQ_IDLE);
  assign done = done_q;
  assign rnd  = rnd_q;

endmodule

// File: tb/tb_romulus_tbc_sequencer.sv
// Scoreboard bench: randomized start/cnt_step against a per-call frame model, plus an R=4 directed run.
module tb_romulus_tbc_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [8:0] stb;   // sen,senc,xen,xenc,yen,yenc,zen,zenc,correct_cnt
    logic [5:0] cst;
    logic [5:0] rnd;
  } frame_t;

  logic clk = 1'b0;
  logic rst, start, cnt_step;
  logic busy, done, sen, senc, xen, xenc, yen, yenc, zen, zenc, correct_cnt;
  logic [5:0] constant, rnd;

  logic start4;
  logic busy4, done4, sen4, senc4, xen4, xenc4, yen4, yenc4, zen4, zenc4, cc4;
  logic [23:0] constant4;
  logic [5:0]  rnd4;

  int total = 0;
  int bad   = 0;
  bit mon_en = 0;

  frame_t exp_q[$];
  int     remaining = 0;
  logic [5:0] model_rnd = 0;

  always #5 clk = ~clk;

  romulus_tbc_sequencer #(.RNDS_PER_CLK(1)) dut (
    .clk(clk), .rst(rst), .start(start), .cnt_step(cnt_step),
    .busy(busy), .done(done), .constant(constant), .rnd(rnd),
    .sen(sen), .senc(senc), .xen(xen), .xenc(xenc), .yen(yen), .yenc(yenc),
    .zen(zen), .zenc(zenc), .correct_cnt(correct_cnt)
  );

  romulus_tbc_sequencer #(.RNDS_PER_CLK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .cnt_step(1'b0),
    .busy(busy4), .done(done4), .constant(constant4), .rnd(rnd4),
    .sen(sen4), .senc(senc4), .xen(xen4), .xenc(xenc4), .yen(yen4), .yenc(yenc4),
    .zen(zen4), .zenc(zenc4), .correct_cnt(cc4)
  );

  function automatic logic [5:0] lfsr(input logic [5:0] r);
    return {r[4:0], ~(r[5] ^ r[4])};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // expected frames of one whole TBC call: 40 RUN, 1 CORR, 1 done
  task automatic push_call();
    logic [5:0] r;
    r = 6'h00;
    for (int i = 1; i <= 40; i++) begin
      r = lfsr(r);
      exp_q.push_back('{1'b1, 1'b0, 9'b111111110, r, 6'(i - 1)});
    end
    exp_q.push_back('{1'b1, 1'b0, 9'b001010100, 6'h00, 6'd40});
    exp_q.push_back('{1'b0, 1'b1, 9'b000000000, 6'h00, 6'd40});
    model_rnd = 6'd40;
    remaining = 41;
  endtask

  task automatic push_cstep();
    exp_q.push_back('{1'b1, 1'b0, 9'b000000101, 6'h00, model_rnd});
    exp_q.push_back('{1'b0, 1'b1, 9'b000000000, 6'h00, model_rnd});
    remaining = 1;
  endtask

  // inputs held across the edge; model consumes them just after it
  task automatic drive(input logic s, input logic c, input logic r);
    start = s; cnt_step = c; rst = r;
    @(posedge clk); #1;
    if (r) begin
      exp_q.delete();
      remaining = 0;
      model_rnd = 0;
    end else if (remaining == 0 && s) push_call();
    else if (remaining == 0 && c) push_cstep();
    else if (remaining > 0) remaining--;
  endtask

  always @(negedge clk) begin
    frame_t act, e;
    if (mon_en) begin
      act = '{busy, done, {sen, senc, xen, xenc, yen, yenc, zen, zenc, correct_cnt}, constant, rnd};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL frame t=%0t got=%h want=%h", $time, act, e);
        end
      end else begin
        total++;
        if (act[22:6] !== 17'h0) begin
          bad++;
          $display("FAIL idle t=%0t got=%h want=0", $time, act[22:6]);
        end
      end
    end
  end

  initial begin
    logic [23:0] exp_first4, exp_last4, last_seen4;
    logic [5:0]  r;
    int cyc, runs;
    bit got_done;

    start4 = 0;
    drive(0, 0, 1);
    drive(0, 0, 1);
    drive(0, 0, 0);
    @(negedge clk);
    check("reset_outputs",
          {busy, done, sen, senc, xen, xenc, yen, yenc, zen, zenc, correct_cnt, constant, rnd},
          32'h0);
    mon_en = 1;

    // start and cnt_step together: RUN must win
    drive(1, 1, 0);
    for (int i = 0; i < 1500; i++)
      drive(($urandom % 10) == 0, ($urandom % 8) == 0, 0);

    // start held continuously: back-to-back calls
    for (int i = 0; i < 150; i++) drive(1, $urandom % 2, 0);

    // abort partway through RUN
    for (int i = 0; i < 60 && remaining != 0; i++) drive(0, 0, 0);
    drive(1, 0, 0);
    for (int i = 0; i < 60 && remaining != 21; i++) drive(0, 0, 0);
    check("rst_mid_run_reached", remaining, 21);
    drive(0, 0, 1);
    for (int i = 0; i < 500; i++)
      drive(($urandom % 12) == 0, ($urandom % 6) == 0, 0);

    for (int i = 0; i < 100 && remaining != 0; i++) drive(0, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    check("queue_drained", exp_q.size(), 0);

    // R=4 directed run
    r = 6'h00;
    for (int i = 0; i < 40; i++) begin
      r = lfsr(r);
      if (i < 4)  exp_first4[6*i +: 6] = r;
      if (i >= 36) exp_last4[6*(i-36) +: 6] = r;
    end
    check("r4_first_literal", exp_first4, {6'h0F, 6'h07, 6'h03, 6'h01});
    @(posedge clk); #1 start4 = 1;
    @(posedge clk); #1 start4 = 0;
    cyc = 1; runs = 0; got_done = 0; last_seen4 = '0;
    @(negedge clk);
    check("r4_first_const", constant4, exp_first4);
    while (!got_done && cyc < 30) begin
      if (done4) got_done = 1;
      else begin
        if (sen4) begin runs++; last_seen4 = constant4; end
        @(negedge clk);
        cyc++;
      end
    end
    check("r4_done_seen", got_done, 1);
    check("r4_done_cycle", cyc, 12);
    check("r4_run_cycles", runs, 10);
    check("r4_last_const", last_seen4, exp_last4);
    check("r4_rnd_final", rnd4, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
